// File: rtl/rc_accum.sv
// rc_accum: reservoir pre-activation accumulator feeding the tanh neuron stage.
// Builds NO signed dot products over an NH-beat frame; a held output buffer lets the next frame accumulate meanwhile.
module rc_accum #(
  parameter  int NO = 8,
  parameter  int NH = 64,
  parameter  int WS = 8,
  parameter  int WR = 8,
  localparam int CW = $clog2(NH),
  localparam int WA = CW - 1 + WS + WR
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iValid_AS_RcWeight,
  output logic                oReady_AS_RcWeight,
  input  logic [WR+NO*WS-1:0] iData_AS_RcWeight,
  output logic                oValid_BM_DeRcAccum,
  input  logic                iReady_BM_DeRcAccum,
  output logic [NO*WA-1:0]    oData_BM_DeRcAccum
);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NO-1:0][WA-1:0] acc_q, acc_d;
  logic [NO-1:0][WA-1:0] obuf_q, obuf_d;
  logic                  full_q, full_d;

  logic                  last_beat, beat_acc, out_xfer;
  logic signed [WA-1:0]  x_ext;
  logic signed [WA-1:0]  w_ext [NO];
  logic [NO-1:0][WA-1:0] prod;

  assign last_beat = (cnt_q == CW'(NH - 1));
  // Only a frame-closing beat must wait, and only while the previous result is still unclaimed.
  assign oReady_AS_RcWeight  = !(last_beat && full_q && !iReady_BM_DeRcAccum);
  assign beat_acc            = iValid_AS_RcWeight && oReady_AS_RcWeight;
  assign out_xfer            = full_q && iReady_BM_DeRcAccum;
  assign oValid_BM_DeRcAccum = full_q;
  assign oData_BM_DeRcAccum  = obuf_q;

  // Operands widened to WA first, so the product lands sign-extended and sums wrap modulo 2^WA.
  always_comb begin
    x_ext = WA'($signed(iData_AS_RcWeight[WR-1:0]));
    for (int i = 0; i < NO; i++) begin
      w_ext[i] = WA'($signed(iData_AS_RcWeight[WR+i*WS +: WS]));
      prod[i]  = x_ext * w_ext[i];
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    obuf_d = obuf_q;
    full_d = full_q;

    if (out_xfer) begin
      full_d = 1'b0;
    end

    // A closing beat re-arms full even when the old result leaves on the same edge.
    if (beat_acc) begin
      if (last_beat) begin
        for (int i = 0; i < NO; i++) begin
          obuf_d[i] = acc_q[i] + prod[i];
        end
        acc_d  = '0;
        cnt_d  = '0;
        full_d = 1'b1;
      end else begin
        for (int i = 0; i < NO; i++) begin
          acc_d[i] = acc_q[i] + prod[i];
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      obuf_q <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      obuf_q <= obuf_d;
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_rc_accum.sv
// tb_rc_accum: directed table-driven bench for rc_accum with NO=2, NH=4, 8-bit operands (17-bit lanes).
// Inputs change and outputs are sampled around the falling clock edge.
module tb_rc_accum;

  localparam int NO = 2;
  localparam int NH = 4;
  localparam int WS = 8;
  localparam int WR = 8;
  localparam int WA = 17;

  logic                iCLK = 1'b0;
  logic                iRST;
  logic                iValid_AS_RcWeight;
  logic                oReady_AS_RcWeight;
  logic [WR+NO*WS-1:0] iData_AS_RcWeight;
  logic                oValid_BM_DeRcAccum;
  logic                iReady_BM_DeRcAccum;
  logic [NO*WA-1:0]    oData_BM_DeRcAccum;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string          name;
    logic [3:0][7:0] x;
    logic [3:0][7:0] w0;
    logic [3:0][7:0] w1;
    logic [16:0]    e0;
    logic [16:0]    e1;
    bit             gaps;
  } vec_t;

  vec_t vecs [5];

  rc_accum #(.NO(NO), .NH(NH), .WS(WS), .WR(WR)) dut (
    .iCLK                (iCLK),
    .iRST                (iRST),
    .iValid_AS_RcWeight  (iValid_AS_RcWeight),
    .oReady_AS_RcWeight  (oReady_AS_RcWeight),
    .iData_AS_RcWeight   (iData_AS_RcWeight),
    .oValid_BM_DeRcAccum (oValid_BM_DeRcAccum),
    .iReady_BM_DeRcAccum (iReady_BM_DeRcAccum),
    .oData_BM_DeRcAccum  (oData_BM_DeRcAccum)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required the bench to finish first");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] lane(input int i);
    return oData_BM_DeRcAccum[i*WA +: WA];
  endfunction

  function automatic logic [16:0] dot(input logic [3:0][7:0] x, input logic [3:0][7:0] w);
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'($signed(x[k])) * int'($signed(w[k]));
    return 17'(s);
  endfunction

  // One beat offered at a falling edge and taken on the next rising edge.
  task automatic send_beat(input string name, input logic [7:0] x, input logic [7:0] w0,
                           input logic [7:0] w1);
    iData_AS_RcWeight  = {w1, w0, x};
    iValid_AS_RcWeight = 1'b1;
    #1;
    check({name, " ready"}, oReady_AS_RcWeight, 1'b1);
    @(negedge iCLK);
    iValid_AS_RcWeight = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, input int nbeats, input bit expect_idle);
    for (int k = 0; k < nbeats; k++) begin
      send_beat(v.name, v.x[k], v.w0[k], v.w1[k]);
      if (expect_idle && k < NH - 1) check({v.name, " valid early"}, oValid_BM_DeRcAccum, 1'b0);
      if (v.gaps && k < NH - 1) begin
        repeat ($urandom_range(1, 3)) begin
          iData_AS_RcWeight = 24'($urandom);
          @(negedge iCLK);
        end
      end
    end
  endtask

  task automatic check_result(input string name, input logic [16:0] e0, input logic [16:0] e1);
    check({name, " valid"}, oValid_BM_DeRcAccum, 1'b1);
    check({name, " lane0"}, lane(0), e0);
    check({name, " lane1"}, lane(1), e1);
  endtask

  initial begin
    vecs[0] = '{"basic",   {8'h04, 8'h03, 8'h02, 8'h01}, {4{8'h01}}, {8'h04, 8'hFD, 8'h02, 8'hFF},
                17'd10, 17'd10, 1'b0};
    vecs[1] = '{"minmin",  {4{8'h80}}, {4{8'h80}}, {4{8'h80}}, 17'h10000, 17'h10000, 1'b0};
    vecs[2] = '{"maxmin",  {4{8'h7F}}, {4{8'h80}}, {4{8'h7F}}, 17'h10200, 17'h0FC04, 1'b0};
    vecs[3] = '{"gaps",    {8'h04, 8'h03, 8'h02, 8'h01}, {4{8'h01}}, {8'h04, 8'hFD, 8'h02, 8'hFF},
                17'd10, 17'd10, 1'b1};
    vecs[4] = '{"mixed",   {8'h07, 8'h00, 8'hFD, 8'h05}, {8'h01, 8'hFA, 8'h04, 8'h02}, {4{8'hFF}},
                17'd5, 17'h1FFF7, 1'b0};

    iRST = 1'b1;
    iValid_AS_RcWeight  = 1'b0;
    iReady_BM_DeRcAccum = 1'b1;
    iData_AS_RcWeight   = '0;
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    #1;
    check("reset valid", oValid_BM_DeRcAccum, 1'b0);
    check("reset data", oData_BM_DeRcAccum, '0);
    check("reset ready", oReady_AS_RcWeight, 1'b1);
    @(negedge iCLK);

    // Table frames: valid rises one cycle after the closing beat and lasts exactly one cycle.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v], NH, 1'b1);
      check_result(vecs[v].name, vecs[v].e0, vecs[v].e1);
      @(negedge iCLK);
      check({vecs[v].name, " valid drop"}, oValid_BM_DeRcAccum, 1'b0);
    end

    // Backpressure: frame B's closing beat stalls behind held result A.
    iReady_BM_DeRcAccum = 1'b0;
    send_frame(vecs[0], NH, 1'b0);
    check_result("bp A", 17'd10, 17'd10);
    send_frame(vecs[4], NH - 1, 1'b0);
    check_result("bp A held", 17'd10, 17'd10);
    iData_AS_RcWeight  = {vecs[4].w1[3], vecs[4].w0[3], vecs[4].x[3]};
    iValid_AS_RcWeight = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp stall ready", oReady_AS_RcWeight, 1'b0);
      check_result("bp stall", 17'd10, 17'd10);
      @(negedge iCLK);
    end
    iReady_BM_DeRcAccum = 1'b1;
    #1;
    check("bp release ready", oReady_AS_RcWeight, 1'b1);
    @(negedge iCLK);
    iValid_AS_RcWeight = 1'b0;
    check_result("bp B", 17'd5, 17'h1FFF7);
    @(negedge iCLK);
    check("bp B drop", oValid_BM_DeRcAccum, 1'b0);

    // Reset with a result pending and a partial frame in the accumulators.
    iReady_BM_DeRcAccum = 1'b0;
    send_frame(vecs[0], NH, 1'b0);
    send_frame(vecs[4], 2, 1'b0);
    check_result("rst pending", 17'd10, 17'd10);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    #1;
    check("rst mid valid", oValid_BM_DeRcAccum, 1'b0);
    check("rst mid data", oData_BM_DeRcAccum, '0);
    check("rst mid ready", oReady_AS_RcWeight, 1'b1);
    @(negedge iCLK);
    iReady_BM_DeRcAccum = 1'b1;
    send_frame(vecs[2], NH, 1'b1);
    check_result("rst fresh", 17'h10200, 17'h0FC04);
    @(negedge iCLK);

    // Streaming: eight frames back to back, one result every NH cycles.
    for (int f = 0; f < 8; f++) begin
      logic [3:0][7:0] sx, sw0, sw1;
      for (int k = 0; k < 4; k++) begin
        sx[k]  = 8'(f * 37 + k * 11 - 60);
        sw0[k] = 8'(k * 29 - f * 13);
        sw1[k] = 8'(100 - f * k * 7);
      end
      for (int k = 0; k < 4; k++) begin
        iData_AS_RcWeight  = {sw1[k], sw0[k], sx[k]};
        iValid_AS_RcWeight = 1'b1;
        #1;
        check("stream ready", oReady_AS_RcWeight, 1'b1);
        @(negedge iCLK);
        check("stream valid", oValid_BM_DeRcAccum, (k == 3) ? 1'b1 : 1'b0);
      end
      check("stream lane0", lane(0), dot(sx, sw0));
      check("stream lane1", lane(1), dot(sx, sw1));
    end
    iValid_AS_RcWeight = 1'b0;
    @(negedge iCLK);
    check("stream end valid", oValid_BM_DeRcAccum, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
